branch_resolve: RTL and testbench
=================================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width of operands, PC and immediate.
REQ-002 SHALL have parameter CNT_W, default 32, width of the mispredict counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port flush  input  1  kill all in-flight branches this cycle.
REQ-006 SHALL have port in_valid  input  1  upstream branch op valid.
REQ-007 SHALL have port in_ready  output  1  block accepts op when in_valid and in_ready are both high.
REQ-008 SHALL have port in_funct3  input  3  branch type: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111.
REQ-009 SHALL have ports in_rs1, in_rs2, in_pc, in_imm  input  XLEN each  operands, branch PC, sign-extended offset.
REQ-010 SHALL have port in_pred_taken  input  1  front-end prediction.
REQ-011 SHALL have port out_valid  output  1  resolved result valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have ports out_taken, out_mispredict, out_illegal  output  1 each  resolution flags.
REQ-014 SHALL have port out_next_pc  output  XLEN  architecturally correct next PC.
REQ-015 SHALL have port redirect_valid  output  1  single-cycle fetch redirect pulse.
REQ-016 SHALL have port redirect_pc  output  XLEN  redirect target, valid with redirect_valid.
REQ-017 SHALL have port mispredict_cnt  output  CNT_W  count of retired mispredicts.

Function
REQ-018 SHALL be a two-stage pipeline (S1 compare, S2 output); accepted op appears on out_valid 2 cycles after acceptance when out_ready stays high.
REQ-019 S1 SHALL register eq = (rs1==rs2), lt = signed rs1<rs2, ltu = unsigned rs1<rs2, pc+imm and pc+4, all modulo 2^XLEN.
REQ-020 taken SHALL be: BEQ eq, BNE !eq, BLT lt, BGE !lt, BLTU ltu, BGEU !ltu.
REQ-021 funct3 010/011 SHALL give out_illegal=1, out_taken=0, out_next_pc=pc+4, out_mispredict=0.
REQ-022 out_next_pc SHALL be pc+imm when taken, else pc+4; out_mispredict = out_taken XOR pred_taken for legal ops.
REQ-023 Each stage SHALL advance when the next stage is empty or advancing; in_ready = !flush && (S1 empty || S1 advancing); no bubbles under continuous traffic.
REQ-024 S2 SHALL hold all out_* stable while out_valid && !out_ready.
REQ-025 redirect_valid SHALL pulse exactly one cycle on the cycle out_valid && out_ready && out_mispredict, with redirect_pc = out_next_pc; otherwise 0.
REQ-026 mispredict_cnt SHALL increment by 1 on each redirect_valid cycle and saturate at all-ones.
REQ-027 flush SHALL clear S1 and S2 valid bits at the next edge, outputs deasserting the following cycle; no op is accepted while flush is high; an S2 result handed over in the flush cycle still produces its redirect and count.
REQ-028 Results SHALL leave in acceptance order; no op is dropped or duplicated absent flush.

Reset
REQ-029 On rst_n low, SHALL asynchronously clear S1/S2 valid, out_valid, redirect_valid, out_taken, out_mispredict, out_illegal to 0, out_next_pc, redirect_pc and mispredict_cnt to 0.
REQ-030 Reset mid-operation SHALL discard in-flight ops; in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-031 funct3 encodings and XLEN default SHALL live in shared package branch_pkg.
REQ-032 Comparison SHALL be one combinational sub-module branch_cmp (eq, lt, ltu outputs), reusing the codebase subtract-based compare scheme.

Verification
REQ-033 BLT rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=1, pc=0x1000, imm=0x40, pred=0 -> taken=1, next_pc=0x1040, mispredict=1, one redirect pulse, cnt=1.
REQ-034 BLTU same operands, pred=0 -> taken=0, next_pc=0x1004, no redirect; BGEU -> taken=1.
REQ-035 BEQ rs1=rs2=0x8000_0000_0000_0000, pc=0xFFFF_FFFF_FFFF_FFFC, imm=8, pred=1 -> taken=1, next_pc=0x4 (wrap), no redirect.
REQ-036 Back-to-back 8 ops with out_ready low for 3 cycles mid-stream -> outputs held stable, all 8 in order, in_ready drops only when both stages full.
REQ-037 flush with two ops in flight -> both vanish, in_ready=0 that cycle, next op resolves normally; funct3=010 -> illegal=1, next_pc=pc+4.
REQ-038 Counter preloaded near max via 2^CNT_W mispredicts (CNT_W=4) -> saturates at 0xF; rst_n low mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared branch definitions: funct3 encodings, default datapath width and
// the taken/legal decode used by the resolve pipeline.
package branch_pkg;

   localparam int XLEN_DEFAULT = 64;

   typedef enum logic [2:0] {
      F3_BEQ  = 3'b000,
      F3_BNE  = 3'b001,
      F3_BLT  = 3'b100,
      F3_BGE  = 3'b101,
      F3_BLTU = 3'b110,
      F3_BGEU = 3'b111
   } funct3_e;

   function automatic logic funct3_legal(input logic [2:0] f);
      return (f != 3'b010) && (f != 3'b011);
   endfunction

   function automatic logic branch_taken(input logic [2:0] f, input logic eq,
                                         input logic lt, input logic ltu);
      logic t;
      t = 1'b0;
      case (f)
         F3_BEQ:  t = eq;
         F3_BNE:  t = !eq;
         F3_BLT:  t = lt;
         F3_BGE:  t = !lt;
         F3_BLTU: t = ltu;
         F3_BGEU: t = !ltu;
         default: t = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational operand compare built on one XLEN+1 bit subtraction:
// the borrow gives the unsigned result, the sign of the difference the signed one.
module branch_cmp #(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            eq,
   output logic            lt,
   output logic            ltu
);

   logic [XLEN:0] diff;

   assign diff = {1'b0, a} - {1'b0, b};
   assign eq   = (diff[XLEN-1:0] == '0);
   assign ltu  = diff[XLEN];
   // Differing signs decide directly; equal signs cannot overflow the difference.
   assign lt   = (a[XLEN-1] ^ b[XLEN-1]) ? a[XLEN-1] : diff[XLEN-1];

endmodule

// File: rtl/branch_resolve.sv
// Two-stage branch resolution: S1 registers compare results and both candidate
// PCs, S2 holds the resolved result and drives the fetch redirect and counter.
module branch_resolve
   import branch_pkg::*;
#(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_funct3,
   input  logic [XLEN-1:0]  in_rs1,
   input  logic [XLEN-1:0]  in_rs2,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [XLEN-1:0]  in_imm,
   input  logic             in_pred_taken,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_taken,
   output logic             out_mispredict,
   output logic             out_illegal,
   output logic [XLEN-1:0]  out_next_pc,
   output logic             redirect_valid,
   output logic [XLEN-1:0]  redirect_pc,
   output logic [CNT_W-1:0] mispredict_cnt
);

   // Handshake: a transfer happens on a rising edge where valid && ready are
   // both high; valid never depends on ready, and a stalled stage holds its data.

   logic            cmp_eq, cmp_lt, cmp_ltu;
   logic            s1_valid, s1_eq, s1_lt, s1_ltu, s1_pred;
   logic [2:0]      s1_funct3;
   logic [XLEN-1:0] s1_target, s1_seq;
   logic            s2_open, s1_open;
   logic            res_legal, res_taken, res_misp;

   branch_cmp #(.XLEN(XLEN)) u_cmp (
      .a   (in_rs1),
      .b   (in_rs2),
      .eq  (cmp_eq),
      .lt  (cmp_lt),
      .ltu (cmp_ltu)
   );

   assign s2_open  = !out_valid || out_ready;
   assign s1_open  = !s1_valid || s2_open;
   assign in_ready = !flush && s1_open;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_eq     <= 1'b0;
         s1_lt     <= 1'b0;
         s1_ltu    <= 1'b0;
         s1_pred   <= 1'b0;
         s1_funct3 <= 3'b000;
         s1_target <= '0;
         s1_seq    <= '0;
      end else if (flush) begin
         s1_valid <= 1'b0;
      end else if (s1_open) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_eq     <= cmp_eq;
            s1_lt     <= cmp_lt;
            s1_ltu    <= cmp_ltu;
            s1_pred   <= in_pred_taken;
            s1_funct3 <= in_funct3;
            s1_target <= in_pc + in_imm;
            s1_seq    <= in_pc + XLEN'(4);
         end
      end
   end

   assign res_legal = funct3_legal(s1_funct3);
   assign res_taken = res_legal && branch_taken(s1_funct3, s1_eq, s1_lt, s1_ltu);
   assign res_misp  = res_legal && (res_taken ^ s1_pred);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid      <= 1'b0;
         out_taken      <= 1'b0;
         out_mispredict <= 1'b0;
         out_illegal    <= 1'b0;
         out_next_pc    <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (s2_open) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_taken      <= res_taken;
            out_mispredict <= res_misp;
            out_illegal    <= !res_legal;
            out_next_pc    <= res_taken ? s1_target : s1_seq;
         end
      end
   end

   // A result handed over in a flush cycle still redirects and counts.
   assign redirect_valid = out_valid && out_ready && out_mispredict;
   assign redirect_pc    = redirect_valid ? out_next_pc : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mispredict_cnt <= '0;
      end else if (redirect_valid && (mispredict_cnt != '1)) begin
         mispredict_cnt <= mispredict_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: vector table, back-to-back stall,
// flush, counter saturation and mid-stream reset sequences.
module tb_branch_resolve;

   localparam int XLEN  = 64;
   localparam int CNT_W = 4;
   localparam int EW    = XLEN + 3;

   typedef struct {
      logic [2:0]      f3;
      logic [XLEN-1:0] rs1, rs2, pc, imm;
      logic            pred;
      logic            taken, misp, ill;
      logic [XLEN-1:0] next;
   } vec_t;

   logic             clk, rst_n, flush, in_valid, in_ready, in_pred_taken;
   logic [2:0]       in_funct3;
   logic [XLEN-1:0]  in_rs1, in_rs2, in_pc, in_imm;
   logic             out_valid, out_ready, out_taken, out_mispredict, out_illegal;
   logic [XLEN-1:0]  out_next_pc, redirect_pc;
   logic             redirect_valid;
   logic [CNT_W-1:0] mispredict_cnt;

   branch_resolve #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm),
      .in_pred_taken(in_pred_taken),
      .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
      .out_mispredict(out_mispredict), .out_illegal(out_illegal),
      .out_next_pc(out_next_pc), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .mispredict_cnt(mispredict_cnt)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int              n_checks = 0;
   int              n_fail   = 0;
   logic [EW-1:0]   exp_q[$];
   int              occ       = 0;
   int              retired   = 0;
   int              stall_seen = 0;
   logic [CNT_W-1:0] exp_cnt  = '0;
   vec_t            vecs[12];

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] f3, input logic [XLEN-1:0] rs1, rs2, pc, imm,
                               input logic pred, taken, misp, ill, input logic [XLEN-1:0] next);
      vec_t v;
      v.f3 = f3; v.rs1 = rs1; v.rs2 = rs2; v.pc = pc; v.imm = imm; v.pred = pred;
      v.taken = taken; v.misp = misp; v.ill = ill; v.next = next;
      return v;
   endfunction

   // driver: present one op, wait for acceptance, record its expected result
   task automatic send(input vec_t v);
      int n;
      in_valid = 1'b1; in_funct3 = v.f3; in_rs1 = v.rs1; in_rs2 = v.rs2;
      in_pc = v.pc; in_imm = v.imm; in_pred_taken = v.pred;
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 50) begin
            chk("send_accept", in_ready, 1);
            break;
         end
      end
      exp_q.push_back({v.taken, v.misp, v.ill, v.next});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // scoreboard / monitor
   logic [EW-1:0] e;
   logic          hs, exp_rdy;
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         occ = 0;
         exp_cnt = '0;
      end else begin
         exp_rdy = !flush && (occ < 2 || out_ready);
         chk("in_ready", in_ready, exp_rdy);
         chk("mispredict_cnt", mispredict_cnt, exp_cnt);
         if (!in_ready && !flush) stall_seen++;
         hs = 1'b0;
         e  = '0;
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("spurious_out_valid", out_valid, 0);
            end else begin
               e = exp_q[0];
               chk("out_taken", out_taken, e[XLEN+2]);
               chk("out_mispredict", out_mispredict, e[XLEN+1]);
               chk("out_illegal", out_illegal, e[XLEN]);
               chk("out_next_pc", out_next_pc, e[XLEN-1:0]);
               hs = out_ready;
            end
         end
         chk("redirect_valid", redirect_valid, hs && e[XLEN+1]);
         if (hs && e[XLEN+1]) chk("redirect_pc", redirect_pc, e[XLEN-1:0]);
         if (flush) occ = 0;
         else occ = occ + ((in_valid && in_ready) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
         if (hs) begin
            void'(exp_q.pop_front());
            retired++;
            if (e[XLEN+1] && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
         end
         if (flush) exp_q.delete();
      end
   end

   initial begin
      int r0;
      int s0;
      vecs[0]  = mk(3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h1000, 64'h40, 0, 1, 1, 0, 64'h1040);
      vecs[1]  = mk(3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h1000, 64'h40, 0, 0, 0, 0, 64'h1004);
      vecs[2]  = mk(3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h1000, 64'h40, 1, 1, 0, 0, 64'h1040);
      vecs[3]  = mk(3'b000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                    64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 1, 1, 0, 0, 64'h4);
      vecs[4]  = mk(3'b001, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                    64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 1, 0, 1, 0, 64'h0);
      vecs[5]  = mk(3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h2000, 64'hFFFF_FFFF_FFFF_FFF0,
                    1, 0, 1, 0, 64'h2004);
      vecs[6]  = mk(3'b101, 64'h5, 64'h5, 64'h2000, 64'hFFFF_FFFF_FFFF_FFF0, 0, 1, 1, 0, 64'h1FF0);
      vecs[7]  = mk(3'b010, 64'h1, 64'h1, 64'h3000, 64'h40, 1, 0, 0, 1, 64'h3004);
      vecs[8]  = mk(3'b011, 64'h7, 64'h7, 64'h3000, 64'h100, 0, 0, 0, 1, 64'h3004);
      vecs[9]  = mk(3'b100, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h100, 64'h20,
                    0, 0, 0, 0, 64'h104);
      vecs[10] = mk(3'b110, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h100, 64'h20,
                    0, 1, 1, 0, 64'h120);
      vecs[11] = mk(3'b000, 64'h3, 64'h4, 64'h500, 64'h10, 0, 0, 0, 0, 64'h504);

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_funct3 = 3'b000; in_rs1 = '0; in_rs2 = '0; in_pc = '0; in_imm = '0; in_pred_taken = 1'b0;
      #12;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_redirect_valid", redirect_valid, 0);
      chk("reset_next_pc", out_next_pc, 0);
      chk("reset_cnt", mispredict_cnt, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      // single ops: latency and resolution
      for (int i = 0; i < 12; i++) begin
         send(vecs[i]);
         @(negedge clk);
         chk("latency_early", out_valid, 0);
         @(negedge clk);
         chk("latency_two", out_valid, 1);
         if (i == 0) begin
            @(negedge clk);
            chk("first_redirect_cnt", mispredict_cnt, 1);
         end
         drain();
      end

      // back-to-back with a three-cycle downstream stall
      r0 = retired;
      s0 = stall_seen;
      fork
         begin
            for (int i = 0; i < 8; i++) send(vecs[i]);
         end
         begin
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      chk("b2b_retired", retired - r0, 8);
      chk("b2b_in_ready_dropped", (stall_seen > s0) ? 1 : 0, 1);

      // flush with both stages full and the output stalled: both vanish
      out_ready = 1'b0;
      send(vecs[0]);
      send(vecs[1]);
      flush = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", out_valid, 0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(vecs[7]);
      drain();

      // flush while S2 hands over a mispredict: that one still counts
      send(vecs[0]);
      send(vecs[6]);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_hs_out_valid", out_valid, 0);
      chk("flush_hs_cnt", mispredict_cnt, 10);
      @(posedge clk);
      #1;

      // saturation
      for (int i = 0; i < 16; i++) send(vecs[0]);
      drain();
      chk("cnt_saturated", mispredict_cnt, 4'hF);

      // reset mid-stream
      out_ready = 1'b0;
      send(vecs[0]);
      send(vecs[2]);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_taken", out_taken, 0);
      chk("arst_mispredict", out_mispredict, 0);
      chk("arst_illegal", out_illegal, 0);
      chk("arst_next_pc", out_next_pc, 0);
      chk("arst_redirect_valid", redirect_valid, 0);
      chk("arst_redirect_pc", redirect_pc, 0);
      chk("arst_cnt", mispredict_cnt, 0);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("arst_in_ready", in_ready, 1);
      chk("arst_no_output", out_valid, 0);
      @(posedge clk);
      #1;
      send(vecs[3]);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
